csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
Machine-mode CSR register file and trap-state holder for the pipeline.
- Writeback is the requester: it drives CSR reads/writes plus exception and trap-return strobes.
- This block answers with read data, registered trap vector/return address and an illegal-access flag.
- It also owns the 64-bit cycle and instret counters.

Parameters:
HART_ID, 32'd0, value returned by mhartid (0xF14)
MISA_VALUE, 32'h4000_0100, read-only misa (RV32I)
MTVEC_RESET, 32'h0000_0000, mtvec value after reset

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, synchronous, active-low
addr_i  in  12  CSR address (instruction[31:20])
data_i  in  32  write operand (rs1 value or zero-extended uimm)
op_i  in  2  funct3[1:0]: 01 RW, 10 RS, 11 RC, 00 none
is_csr_i  in  1  valid CSR instruction in writeback
we_exc_i  in  1  trap entry this cycle
mcause_d_i  in  32  cause to latch on trap
mepc_d_i  in  32  faulting PC
mtval_d_i  in  32  trap value
mret_i  in  1  MRET in writeback
retire_i  in  1  instruction retires this cycle
data_out_o  out  32  old CSR value (combinational read)
mtvec_o  out  32  current mtvec
mepc_o  out  32  current mepc, used as the MRET target
illegal_o  out  1  illegal CSR access (combinational)

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] hardwired 2'b11; all other bits read 0.
  - misa 0x301: read-only; writes ignored, not illegal.
  - mie 0x304, mscratch 0x340: full 32 bits.
  - mtvec 0x305: bits[1:0] forced 00 (direct mode).
  - mepc 0x341: bits[1:0] forced 00.
  - mcause 0x342, mtval 0x343: full 32 bits.
  - mip 0x344: reads 0.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - Read-only: cycle/instret aliases 0xC00/0xC02/0xC80/0xC82, mvendorid/marchid/mimpid 0xF11-0xF13 (read 0), mhartid 0xF14.
- Read: data_out_o is the pre-write value, zero latency. Unimplemented address reads 0.
- Write value:
  - RW: data_i.
  - RS: old | data_i.
  - RC: old & ~data_i.
  - The write commits at the next edge when is_csr_i=1, op_i!=00, illegal_o=0 and we_exc_i=0.
- illegal_o = is_csr_i & (unimplemented address | (addr_i[11:10]==2'b11 & write attempted)).
  - Write attempted: op_i==01, or op_i in {10,11} with data_i!=0.
  - RS/RC with data_i==0 to a read-only CSR is legal and only reads.
  - Illegal access: no state change.
- Priority of simultaneous events: we_exc_i > mret_i > CSR write.
- Trap entry (we_exc_i=1):
  - mepc <= mepc_d_i & ~3; mcause <= mcause_d_i; mtval <= mtval_d_i.
  - MPIE <= MIE; MIE <= 0.
  - Any CSR write in the same cycle is dropped.
- MRET (mret_i=1, no exception): MIE <= MPIE; MPIE <= 1.
- Counters:
  - mcycle increments by 1 every cycle.
  - minstret increments when retire_i & ~we_exc_i.
  - Both are 64-bit; carry propagates low to high; wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - A write to one half in a cycle loads the written value into that half. The other half takes its own half of (counter+1), or of counter when the counter does not increment that cycle.
  - A written counter value is visible unincremented on the following cycle.
- Reset (rst_i=0 at edge):
  - mstatus MIE=0, MPIE=0.
  - mtvec=MTVEC_RESET.
  - mie, mscratch, mepc, mcause, mtval, counters = 0.
  - Reset overrides every other input in the same cycle, including mid-trap.
- mtvec_o and mepc_o are direct register outputs; a new value is visible the cycle after the write.

Decomposition:
- Shared package csr_pkg:
  - CSR address constants (CSR_MSTATUS … CSR_MHARTID).
  - op encodings OP_RW/OP_RS/OP_RC.
  - mstatus bit indices MIE=3, MPIE=7.
  - Exception cause codes: 0 inst misaligned, 2 illegal, 4 load misaligned, 6 store misaligned.
- Sub-module csr_counter64: 64-bit counter with increment enable and half-word write port, instantiated twice (cycle, instret).

Test Plan:
- Reset, then read 0x305 and 0xF14 -> data_out_o=MTVEC_RESET and HART_ID; mcycle reads 1 on the first cycle after reset release and increments each cycle.
- Write mtvec: RW 0x305 data 0x0000_1237 -> next-cycle mtvec_o=0x0000_1234.
- Set/clear mscratch: RS 0x340 with 0xF0 on 0x0F -> reads 0xFF; then RC with 0x0F -> reads 0xF0.
- Trap entry: mstatus MIE=1 + RW mscratch simultaneous with we_exc_i, mepc_d_i=0x103, mcause=2, mtval=0xDEAD -> mepc_o=0x100, mcause=2, mtval=0xDEAD, MIE=0, MPIE=1, mscratch unchanged.
- Trap return: MRET afterwards -> MIE=1, MPIE=1.
- Read-only violation: RW 0xC00 data 5 -> illegal_o=1, counter unaffected. RS 0xC00 data 0 -> illegal_o=0, read returns cycle. Address 0x7C0 -> illegal_o=1.
- Counter carry: RW mcycle=0xFFFF_FFFF, mcycleh=0 -> the cycle after the write mcycle=0xFFFF_FFFF, mcycleh=0; one cycle later mcycle=0, mcycleh=1.
- Retire blocking: retire_i with we_exc_i -> minstret unchanged.

Source files
------------

// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the machine-mode CSR file:
//   - CSR address constants for every implemented register
//   - CSR operation encodings (funct3[1:0])
//   - mstatus bit positions
//   - synchronous exception cause codes
//   - helper that applies a CSR read-modify-write operation
// -----------------------------------------------------------------------------
package csr_pkg;

    // Machine-mode trap setup / handling
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;

    // Machine counters (writable)
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // User-level read-only counter aliases
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // Machine information registers (read-only)
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // CSR operation, taken from funct3[1:0] of the CSR instruction
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    // mstatus fields that exist in this machine-only implementation
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Synchronous exception causes raised by the pipeline
    localparam logic [31:0] CAUSE_INST_MISALIGNED  = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL_INST     = 32'd2;
    localparam logic [31:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MISALIGNED = 32'd6;

    // Counter instance indices inside csr_file
    localparam int NUM_CNT     = 2;
    localparam int CNT_CYCLE   = 0;
    localparam int CNT_INSTRET = 1;

    // New CSR value produced by a read-modify-write operation
    function automatic logic [31:0] csr_apply_op(
        input csr_op_e     op,
        input logic [31:0] old_val,
        input logic [31:0] operand
    );
        logic [31:0] result;
        case (op)
            OP_RW:   result = operand;
            OP_RS:   result = old_val | operand;
            OP_RC:   result = old_val & ~operand;
            default: result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// -----------------------------------------------------------------------------
// csr_counter64
// 64-bit free-running counter with an increment enable and independent
// 32-bit write ports for the low and high halves.
//   clk_i     clock
//   rst_i     synchronous active-low reset, clears the counter
//   inc_i     add one this cycle
//   wr_lo_i   load wdata_i into bits [31:0]
//   wr_hi_i   load wdata_i into bits [63:32]
//   wdata_i   write value
//   count_o   current count
// A written half takes the written value as-is (no increment applied); the
// other half takes its part of count+inc so that a carry out of a written
// low half still reaches the high half consistently.
// -----------------------------------------------------------------------------
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] count_reg;
    logic [63:0] count_next;
    logic [63:0] count_inc;

    always_comb begin
        count_inc  = count_reg + {63'd0, inc_i};
        count_next = count_inc;
        if (wr_lo_i) begin
            count_next[31:0] = wdata_i;
        end
        if (wr_hi_i) begin
            count_next[63:32] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file
// Machine-mode CSR register file and trap-state holder. Writeback issues CSR
// accesses, trap entries and MRETs; this block returns the old CSR value,
// flags illegal accesses and owns the cycle / instret counters.
//   clk_i        clock
//   rst_i        synchronous active-low reset
//   addr_i       CSR address
//   data_i       write operand (rs1 or zero-extended uimm)
//   op_i         01 RW, 10 RS, 11 RC, 00 none
//   is_csr_i     valid CSR instruction in writeback
//   we_exc_i     trap entry this cycle
//   mcause_d_i   cause latched on trap
//   mepc_d_i     faulting PC latched on trap
//   mtval_d_i    trap value latched on trap
//   mret_i       MRET in writeback
//   retire_i     an instruction retires this cycle
//   data_out_o   pre-write CSR value (combinational)
//   mtvec_o      current mtvec (registered)
//   mepc_o       current mepc, MRET target (registered)
//   illegal_o    illegal CSR access (combinational)
// -----------------------------------------------------------------------------
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  op_i,
    input  logic        is_csr_i,
    input  logic        we_exc_i,
    input  logic [31:0] mcause_d_i,
    input  logic [31:0] mepc_d_i,
    input  logic [31:0] mtval_d_i,
    input  logic        mret_i,
    input  logic        retire_i,
    output logic [31:0] data_out_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        illegal_o
);

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic        mstatus_mie_reg,  mstatus_mie_next;
    logic        mstatus_mpie_reg, mstatus_mpie_next;
    logic [31:0] mie_reg,      mie_next;
    logic [31:0] mtvec_reg,    mtvec_next;
    logic [31:0] mscratch_reg, mscratch_next;
    logic [31:0] mepc_reg,     mepc_next;
    logic [31:0] mcause_reg,   mcause_next;
    logic [31:0] mtval_reg,    mtval_next;

    csr_op_e     op;
    logic [31:0] mstatus_rd;
    logic [31:0] rdata;
    logic        addr_impl;
    logic        write_attempt;
    logic        illegal;
    logic        csr_wr_en;
    logic [31:0] wval;

    // Counter plumbing, indexed by CNT_CYCLE / CNT_INSTRET
    logic [NUM_CNT-1:0] cnt_inc;
    logic [NUM_CNT-1:0] cnt_wr_lo;
    logic [NUM_CNT-1:0] cnt_wr_hi;
    logic [63:0]        cnt_val [NUM_CNT];

    assign op = csr_op_e'(op_i);

    // ------------------------------------------------------------------
    // Read path: zero-latency mux; also identifies implemented addresses
    // ------------------------------------------------------------------
    always_comb begin
        mstatus_rd                                = '0;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_rd[MSTATUS_MPIE]                  = mstatus_mpie_reg;
        mstatus_rd[MSTATUS_MIE]                   = mstatus_mie_reg;
    end

    always_comb begin
        rdata     = '0;
        addr_impl = 1'b1;
        case (addr_i)
            CSR_MSTATUS:                 rdata = mstatus_rd;
            CSR_MISA:                    rdata = MISA_VALUE;
            CSR_MIE:                     rdata = mie_reg;
            CSR_MTVEC:                   rdata = mtvec_reg;
            CSR_MSCRATCH:                rdata = mscratch_reg;
            CSR_MEPC:                    rdata = mepc_reg;
            CSR_MCAUSE:                  rdata = mcause_reg;
            CSR_MTVAL:                   rdata = mtval_reg;
            CSR_MIP:                     rdata = '0;
            CSR_MCYCLE,   CSR_CYCLE:     rdata = cnt_val[CNT_CYCLE][31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    rdata = cnt_val[CNT_CYCLE][63:32];
            CSR_MINSTRET, CSR_INSTRET:   rdata = cnt_val[CNT_INSTRET][31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rdata = cnt_val[CNT_INSTRET][63:32];
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = '0;
            CSR_MHARTID:                 rdata = HART_ID;
            default:                     addr_impl = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Access legality and write value
    // ------------------------------------------------------------------
    // RS/RC with a zero operand only reads, so it is legal on read-only CSRs.
    assign write_attempt = (op == OP_RW) ||
                           (((op == OP_RS) || (op == OP_RC)) && (data_i != 32'd0));

    // Address space 0xC00-0xFFF is read-only by encoding.
    assign illegal = is_csr_i &&
                     (!addr_impl || ((addr_i[11:10] == 2'b11) && write_attempt));

    assign csr_wr_en = is_csr_i && (op != OP_NONE) && !illegal && !we_exc_i;
    assign wval      = csr_apply_op(op, rdata, data_i);

    // ------------------------------------------------------------------
    // Next-state: trap entry > MRET > CSR write
    // ------------------------------------------------------------------
    always_comb begin
        mstatus_mie_next  = mstatus_mie_reg;
        mstatus_mpie_next = mstatus_mpie_reg;
        mie_next          = mie_reg;
        mtvec_next        = mtvec_reg;
        mscratch_next     = mscratch_reg;
        mepc_next         = mepc_reg;
        mcause_next       = mcause_reg;
        mtval_next        = mtval_reg;

        if (we_exc_i) begin
            mepc_next         = mepc_d_i & ~32'h3;
            mcause_next       = mcause_d_i;
            mtval_next        = mtval_d_i;
            mstatus_mpie_next = mstatus_mie_reg;
            mstatus_mie_next  = 1'b0;
        end else begin
            if (mret_i) begin
                mstatus_mie_next  = mstatus_mpie_reg;
                mstatus_mpie_next = 1'b1;
            end else if (csr_wr_en && (addr_i == CSR_MSTATUS)) begin
                mstatus_mie_next  = wval[MSTATUS_MIE];
                mstatus_mpie_next = wval[MSTATUS_MPIE];
            end

            if (csr_wr_en) begin
                case (addr_i)
                    CSR_MIE:      mie_next      = wval;
                    CSR_MTVEC:    mtvec_next    = wval & ~32'h3;
                    CSR_MSCRATCH: mscratch_next = wval;
                    CSR_MEPC:     mepc_next     = wval & ~32'h3;
                    CSR_MCAUSE:   mcause_next   = wval;
                    CSR_MTVAL:    mtval_next    = wval;
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= '0;
            mtvec_reg        <= MTVEC_RESET;
            mscratch_reg     <= '0;
            mepc_reg         <= '0;
            mcause_reg       <= '0;
            mtval_reg        <= '0;
        end else begin
            mstatus_mie_reg  <= mstatus_mie_next;
            mstatus_mpie_reg <= mstatus_mpie_next;
            mie_reg          <= mie_next;
            mtvec_reg        <= mtvec_next;
            mscratch_reg     <= mscratch_next;
            mepc_reg         <= mepc_next;
            mcause_reg       <= mcause_next;
            mtval_reg        <= mtval_next;
        end
    end

    // ------------------------------------------------------------------
    // 64-bit counters
    // ------------------------------------------------------------------
    // A trapping instruction does not retire, so trap entry masks retire_i.
    assign cnt_inc[CNT_CYCLE]   = 1'b1;
    assign cnt_inc[CNT_INSTRET] = retire_i && !we_exc_i;

    assign cnt_wr_lo[CNT_CYCLE]   = csr_wr_en && (addr_i == CSR_MCYCLE);
    assign cnt_wr_hi[CNT_CYCLE]   = csr_wr_en && (addr_i == CSR_MCYCLEH);
    assign cnt_wr_lo[CNT_INSTRET] = csr_wr_en && (addr_i == CSR_MINSTRET);
    assign cnt_wr_hi[CNT_INSTRET] = csr_wr_en && (addr_i == CSR_MINSTRETH);

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            csr_counter64 u_cnt (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .inc_i   (cnt_inc[gi]),
                .wr_lo_i (cnt_wr_lo[gi]),
                .wr_hi_i (cnt_wr_hi[gi]),
                .wdata_i (wval),
                .count_o (cnt_val[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_out_o = rdata;
    assign illegal_o  = illegal;
    assign mtvec_o    = mtvec_reg;
    assign mepc_o     = mepc_reg;

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;
    import csr_pkg::*;

    localparam logic [31:0] TB_HART_ID     = 32'h0000_0007;
    localparam logic [31:0] TB_MISA        = 32'h4000_0100;
    localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] data = '0;
    logic [1:0]  op = '0;
    logic        is_csr = 1'b0;
    logic        we_exc = 1'b0;
    logic [31:0] mcause_d = '0;
    logic [31:0] mepc_d = '0;
    logic [31:0] mtval_d = '0;
    logic        mret = 1'b0;
    logic        retire = 1'b0;
    logic [31:0] data_out;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    csr_file #(
        .HART_ID     (TB_HART_ID),
        .MISA_VALUE  (TB_MISA),
        .MTVEC_RESET (TB_MTVEC_RESET)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .addr_i     (addr),
        .data_i     (data),
        .op_i       (op),
        .is_csr_i   (is_csr),
        .we_exc_i   (we_exc),
        .mcause_d_i (mcause_d),
        .mepc_d_i   (mepc_d),
        .mtval_d_i  (mtval_d),
        .mret_i     (mret),
        .retire_i   (retire),
        .data_out_o (data_out),
        .mtvec_o    (mtvec),
        .mepc_o     (mepc),
        .illegal_o  (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [1:0]  op;
        logic        is_csr;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock: the posedge commits the inputs held so far, then all
    // strobes are cleared at the following negedge.
    task automatic step();
        @(negedge clk);
        addr   = '0;
        data   = '0;
        op     = 2'b00;
        is_csr = 1'b0;
        we_exc = 1'b0;
        mret   = 1'b0;
        retire = 1'b0;
    endtask

    task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic [1:0] o);
        addr   = a;
        data   = d;
        op     = o;
        is_csr = 1'b1;
    endtask

    // Combinational read within the current low phase (uses 1 ns).
    task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        drive(a, 32'd0, 2'b00);
        #1;
        check(name, data_out, exp);
        $display("read addr=%h data=%h", a, data_out);
    endtask

    initial begin
        //            addr     data          op     csr   chk   exp_rd         ill
        vecs[0]  = '{12'h305, 32'h0,        2'b00, 1'b1, 1'b1, 32'h0000_0080, 1'b0};
        vecs[1]  = '{12'hF14, 32'h0,        2'b00, 1'b1, 1'b1, 32'h0000_0007, 1'b0};
        vecs[2]  = '{12'h305, 32'h1237,     2'b01, 1'b1, 1'b1, 32'h0000_0080, 1'b0};
        vecs[3]  = '{12'h305, 32'h0,        2'b00, 1'b1, 1'b1, 32'h0000_1234, 1'b0};
        vecs[4]  = '{12'h340, 32'h0F,       2'b01, 1'b1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[5]  = '{12'h340, 32'hF0,       2'b10, 1'b1, 1'b1, 32'h0000_000F, 1'b0};
        vecs[6]  = '{12'h340, 32'h0F,       2'b11, 1'b1, 1'b1, 32'h0000_00FF, 1'b0};
        vecs[7]  = '{12'h340, 32'h0,        2'b00, 1'b1, 1'b1, 32'h0000_00F0, 1'b0};
        vecs[8]  = '{12'h301, 32'h0,        2'b01, 1'b1, 1'b1, 32'h4000_0100, 1'b0};
        vecs[9]  = '{12'h301, 32'h0,        2'b00, 1'b1, 1'b1, 32'h4000_0100, 1'b0};
        vecs[10] = '{12'hC00, 32'h5,        2'b01, 1'b1, 1'b0, 32'h0,         1'b1};
        vecs[11] = '{12'h7C0, 32'h0,        2'b00, 1'b1, 1'b1, 32'h0,         1'b1};
        vecs[12] = '{12'h7C0, 32'h0,        2'b00, 1'b0, 1'b1, 32'h0,         1'b0};
        vecs[13] = '{12'hF14, 32'h0,        2'b10, 1'b1, 1'b1, 32'h0000_0007, 1'b0};
        vecs[14] = '{12'hF11, 32'h1,        2'b11, 1'b1, 1'b1, 32'h0,         1'b1};
        vecs[15] = '{12'h341, 32'h207,      2'b01, 1'b1, 1'b1, 32'h0,         1'b0};
        vecs[16] = '{12'h341, 32'h0,        2'b00, 1'b1, 1'b1, 32'h0000_0204, 1'b0};
        vecs[17] = '{12'h300, 32'hFFFF_FFFF,2'b01, 1'b1, 1'b1, 32'h0000_1800, 1'b0};
        vecs[18] = '{12'h300, 32'h0,        2'b00, 1'b1, 1'b1, 32'h0000_1888, 1'b0};
        vecs[19] = '{12'h300, 32'h88,       2'b11, 1'b1, 1'b1, 32'h0000_1888, 1'b0};
        vecs[20] = '{12'h300, 32'h0,        2'b00, 1'b1, 1'b1, 32'h0000_1800, 1'b0};
        vecs[21] = '{12'h344, 32'h5,        2'b01, 1'b1, 1'b1, 32'h0,         1'b0};
        vecs[22] = '{12'h344, 32'h0,        2'b00, 1'b1, 1'b1, 32'h0,         1'b0};
        vecs[23] = '{12'h304, 32'hA5A5,     2'b01, 1'b1, 1'b1, 32'h0,         1'b0};
        vecs[24] = '{12'h304, 32'h0,        2'b00, 1'b1, 1'b1, 32'h0000_A5A5, 1'b0};
        vecs[25] = '{12'h343, 32'h1,        2'b01, 1'b1, 1'b1, 32'h0,         1'b0};
        vecs[26] = '{12'h343, 32'h0,        2'b00, 1'b1, 1'b1, 32'h0000_0001, 1'b0};

        // ---------------- reset ----------------
        repeat (3) step();
        #1;
        check("rst_mtvec", mtvec, TB_MTVEC_RESET);
        check("rst_mepc", mepc, 32'h0);
        rd_check("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        rd_check("rst_mcycle", CSR_MCYCLE, 32'h0);
        rst = 1'b1;

        step();
        rd_check("mcycle_first", CSR_MCYCLE, 32'd1);
        step();
        rd_check("mcycle_second", CSR_MCYCLE, 32'd2);

        // ---------------- table vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            step();
            drive(vecs[i].addr, vecs[i].data, vecs[i].op);
            is_csr = vecs[i].is_csr;
            #1;
            $display("vec %0d addr=%h op=%0d data=%h rd=%h ill=%b",
                     i, vecs[i].addr, vecs[i].op, vecs[i].data, data_out, illegal);
            if (vecs[i].chk_rd) check("vec_rd", data_out, vecs[i].exp_rd);
            check("vec_ill", {31'd0, illegal}, {31'd0, vecs[i].exp_ill});
        end

        // ---------------- mtvec register output latency ----------------
        step();
        drive(CSR_MTVEC, 32'h0000_5679, 2'b01);
        #1;
        check("mtvec_before", mtvec, 32'h0000_1234);
        step();
        #1;
        check("mtvec_after", mtvec, 32'h0000_5678);

        // ---------------- trap entry ----------------
        step();
        drive(CSR_MSTATUS, 32'h8, 2'b01);       // MIE=1, MPIE=0
        step();
        drive(CSR_MSCRATCH, 32'h1111, 2'b01);    // dropped by the trap
        we_exc   = 1'b1;
        mepc_d   = 32'h103;
        mcause_d = CAUSE_ILLEGAL_INST;
        mtval_d  = 32'hDEAD;
        #1;
        $display("trap entry mepc_d=%h cause=%h", mepc_d, mcause_d);
        step();
        #1;
        check("trap_mepc", mepc, 32'h100);
        rd_check("trap_mcause", CSR_MCAUSE, 32'd2);
        rd_check("trap_mtval", CSR_MTVAL, 32'hDEAD);
        rd_check("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);
        step();
        rd_check("trap_mscratch", CSR_MSCRATCH, 32'h0000_00F0);

        // ---------------- MRET ----------------
        mret = 1'b1;
        step();
        rd_check("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
        check("mret_mepc", mepc, 32'h100);

        // ---------------- counter carry ----------------
        step();
        drive(CSR_MCYCLEH, 32'h0, 2'b01);
        step();
        drive(CSR_MCYCLE, 32'hFFFF_FFFF, 2'b01);
        step();
        rd_check("carry_lo0", CSR_MCYCLE, 32'hFFFF_FFFF);
        rd_check("carry_hi0", CSR_MCYCLEH, 32'h0);
        step();
        rd_check("carry_lo1", CSR_MCYCLE, 32'h0);
        rd_check("carry_hi1", CSR_MCYCLEH, 32'h1);

        // ---------------- read-only aliases ----------------
        step();
        drive(CSR_CYCLE, 32'h0, 2'b10);
        #1;
        check("rs0_cycle_rd", data_out, 32'd1);
        check("rs0_cycle_ill", {31'd0, illegal}, 32'd0);
        drive(CSR_CYCLEH, 32'h0, 2'b11);
        #1;
        check("rc0_cycleh_rd", data_out, 32'd1);
        step();
        drive(CSR_CYCLE, 32'h5, 2'b01);
        #1;
        check("ro_write_ill", {31'd0, illegal}, 32'd1);
        check("ro_write_rd", data_out, 32'd2);
        $display("ro write addr=%h ill=%b", addr, illegal);
        step();
        rd_check("ro_cycle_unaffected", CSR_MCYCLE, 32'd3);
        rd_check("ro_cycleh_unaffected", CSR_MCYCLEH, 32'd1);

        // ---------------- retire / minstret ----------------
        rd_check("instret_start", CSR_MINSTRET, 32'd0);
        retire = 1'b1;
        step();
        rd_check("instret_one", CSR_MINSTRET, 32'd1);
        retire   = 1'b1;
        we_exc   = 1'b1;
        mepc_d   = 32'h200;
        mcause_d = CAUSE_LOAD_MISALIGNED;
        mtval_d  = 32'h0;
        step();
        rd_check("instret_blocked", CSR_MINSTRET, 32'd1);
        rd_check("instret_alias", CSR_INSTRET, 32'd1);
        rd_check("instreth_alias", CSR_INSTRETH, 32'd0);
        rd_check("trap2_mcause", CSR_MCAUSE, 32'd4);

        // ---------------- reset in the middle of a trap ----------------
        step();
        rst      = 1'b0;
        we_exc   = 1'b1;
        mepc_d   = 32'h444;
        mcause_d = CAUSE_STORE_MISALIGNED;
        retire   = 1'b1;
        drive(CSR_MTVEC, 32'h9999, 2'b01);
        step();
        rst = 1'b1;
        #1;
        check("rst2_mtvec", mtvec, TB_MTVEC_RESET);
        check("rst2_mepc", mepc, 32'h0);
        rd_check("rst2_mcause", CSR_MCAUSE, 32'h0);
        rd_check("rst2_mstatus", CSR_MSTATUS, 32'h0000_1800);
        rd_check("rst2_minstret", CSR_MINSTRET, 32'h0);
        step();
        rd_check("rst2_mcycle", CSR_MCYCLE, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
